tanh_pair_scheduler: RTL and testbench
======================================

# tanh_pair_scheduler

Stream front-end for the 2-lane Q5.11 tanh datapath. It accepts a scalar valid/ready element stream, packs consecutive elements into lane pairs and issues them to the fixed-latency datapath, which has no backpressure. Credit accounting guarantees every in-flight result has a slot in the result buffer. Results are unpacked back into an in-order scalar valid/ready stream with the `last` marker preserved.

## Interface
- `LAT`, 3: datapath latency in cycles, from `dp_valid` to `dp_valid_out`.
- `FIFO_DEPTH`, 4: result buffer depth in pair entries; minimum 2.
- `FLUSH_CYC`, 8: idle cycles a lone held element waits for a partner before it is issued alone; minimum 1.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `s_valid` in 1: input element valid.
- `s_ready` out 1: input element ready.
- `s_data` in 16: input element, signed Q5.11.
- `s_last` in 1: end-of-vector marker.
- `dp_x0`, `dp_x1` out 16: lane operands to the datapath (registered).
- `dp_valid` out 1: datapath `valid_in` (registered).
- `dp_y0`, `dp_y1` in 16: lane results from the datapath.
- `dp_valid_out` in 1: datapath result valid.
- `m_valid` out 1: output element valid.
- `m_ready` in 1: output element ready.
- `m_data` out 16: result, Q5.11.
- `m_last` out 1: end-of-vector marker, aligned with `m_data`.
- `busy` out 1: high when a pair is held, in flight or buffered.
- `err` out 1: sticky flag for a tracker/datapath valid mismatch.

## Operation
- Credit: `free = FIFO_DEPTH - fifo_count - inflight`. `s_ready = (free >= 1)`. A flush issue also requires `free >= 1`.
- `inflight` increments on each `dp_valid` cycle and decrements on each `dp_valid_out` cycle. If both happen in the same cycle, it is unchanged.
- Packer FSM has two states.
  - IDLE:
    - Accept with `s_last=1`: issue `{s_data, 0}` with mask 01 and lane-0 last; stay in IDLE.
    - Accept with `s_last=0`: hold the element in the lane-0 register, clear the timer, go to HALF.
  - HALF:
    - Accept: issue `{held, s_data}` with mask 11 and lane-1 last = `s_last`; go to IDLE.
    - No accept: the timer increments, saturating at `FLUSH_CYC-1`.
    - Flush: when the timer is at `FLUSH_CYC-1` and `free >= 1`, issue `{held, 0}` with mask 01 and last 0; go to IDLE.
    - If an accept and a timeout coincide, the accept wins and a full pair is issued.
- Issue sets `dp_x0`, `dp_x1` and `dp_valid` at the issuing edge. `dp_valid` stays high for one cycle per pair. Unused operands are 0.
- Tracker: a `LAT`-deep shift register of `{valid, mask[1:0], last[1:0]}` that advances every cycle.
  - When `dp_valid_out` is high, `{dp_y0, dp_y1, mask, last}` from the tracker tail is written to the FIFO.
  - If the tail valid differs from `dp_valid_out`, `err` sets and stays set until reset. The FIFO is not written on a mismatch.
- Unpacker:
  - `m_valid` equals FIFO not-empty. A lane pointer `sel` selects `m_data` and `m_last` from the head entry.
  - On an `m_valid && m_ready` handshake: if `sel=0` and mask[1]=1, set `sel=1`. Otherwise pop the entry and set `sel=0`.
- `busy = (state==HALF) | (inflight!=0) | fifo not-empty`.

## Timing
- Reset values: `dp_x0`, `dp_x1`, `dp_valid`, `m_data`, `m_last`, `m_valid`, `err` and `busy` are all 0. State is IDLE; timer, `sel`, counters and tracker are cleared. `s_ready` is 1 after reset deassertion because `free = FIFO_DEPTH`.
- Reset mid-operation discards held, in-flight and buffered data. Results from the datapath during the first `LAT` cycles after reset are ignored only if the datapath shares the reset.
- Lone `last` element accepted at edge k: `dp_valid` is high in cycle k+1, the result is written at edge k+1+LAT, and `m_valid` rises in cycle k+2+LAT.
- Full-rate throughput is one element per cycle, i.e. one pair every 2 cycles. A single-lane stream with a stalled sink drains credits in `FIFO_DEPTH` issues, after which `s_ready` drops.
- FIFO full cannot occur by construction. If `fifo_count + inflight > FIFO_DEPTH` is ever reached, that is an assertion failure in the bench.

## Structure
- Shared package `tanh_pkg` holds:
  - `Q_W=16` and the Q5.11 one (2048);
  - the pair-entry type `{y0, y1, mask[1:0], last[1:0]}`;
  - the packer state encoding.
- One sub-module, `tanh_pair_fifo`: a synchronous FIFO of pair entries with count output and asynchronous active-low reset.

## Test plan
- Reset, then `s_data = 0x0000` with `last=1` into the tanh datapath: `m_data = 0x0000`, `m_last = 1`, `m_valid` rises 5 cycles (LAT+2) after the accept edge.
- Back-to-back stream -8192, 0, 8192, 0 (last on the final element): `dp_valid` pulses twice with mask 11; outputs are -2038, 0, 2038, 0 in order, with `m_last` on the 4th output only.
- Single element 8192 with no follow-up and `last=0`: flush issues after 8 cycles in HALF; output is 2038 with `m_last = 0`.
- Partner element arrives exactly in the timeout cycle: one full pair is issued, with no flush and no duplicate.
- `m_ready = 0` with a continuous input stream: `s_ready` drops once buffered plus in-flight pairs reach 4. Releasing `m_ready` drains all results in order with no loss.
- Datapath model drops one `dp_valid_out`: `err` rises at the tracker tail cycle and stays high until `rst_n` is asserted low.

Source files
------------

// File: rtl/tanh_pkg.sv
// Shared types for the 2-lane Q5.11 tanh scheduler: operand width, the
// buffered pair-entry layout and the packer state encoding.
package tanh_pkg;

  localparam int Q_W = 16;
  localparam logic signed [Q_W-1:0] Q_ONE = 16'sd2048;

  // mask[0]/last[0] belong to lane 0, mask[1]/last[1] to lane 1
  typedef struct packed {
    logic [Q_W-1:0] y0;
    logic [Q_W-1:0] y1;
    logic [1:0]     mask;
    logic [1:0]     last;
  } pair_t;

  localparam int PAIR_W = $bits(pair_t);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HALF = 1'b1
  } pack_state_t;

endpackage

// File: rtl/tanh_pair_fifo.sv
// Show-ahead FIFO of pair entries with an occupancy count; the head entry is
// visible on rd_data whenever the FIFO is not empty.
module tanh_pair_fifo
  import tanh_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [PAIR_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [PAIR_W-1:0] rd_data,
  output logic [CW-1:0]     count,
  output logic              empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PAIR_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]     count_reg;
  logic              do_wr, do_rd;

  // Pointers wrap explicitly so DEPTH need not be a power of two
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count_reg == '0);
  assign do_wr   = wr_en && (count_reg != CW'(DEPTH));
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr_reg];
  assign count   = count_reg;

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_reg] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_wr) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (do_rd) rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      case ({do_wr, do_rd})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/tanh_pair_scheduler.sv
// Packs a scalar element stream into lane pairs for the fixed-latency tanh
// datapath, tracks in-flight pairs against buffer credits, and unpacks results.
module tanh_pair_scheduler
  import tanh_pkg::*;
#(
  parameter int LAT        = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int FLUSH_CYC  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [15:0] s_data,
  input  logic        s_last,
  output logic [15:0] dp_x0,
  output logic [15:0] dp_x1,
  output logic        dp_valid,
  input  logic [15:0] dp_y0,
  input  logic [15:0] dp_y1,
  input  logic        dp_valid_out,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [15:0] m_data,
  output logic        m_last,
  output logic        busy,
  output logic        err
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [TW-1:0] TIMEOUT = TW'(FLUSH_CYC - 1);

  typedef struct packed {
    logic       valid;
    logic [1:0] mask;
    logic [1:0] last;
  } trk_t;

  pack_state_t       state_reg, state_next;
  logic [Q_W-1:0]    held_reg, held_next;
  logic [TW-1:0]     timer_reg, timer_next;
  logic              issue;
  logic [Q_W-1:0]    iss_x0, iss_x1;
  logic [1:0]        iss_mask, iss_last;
  logic [1:0]        dp_mask_reg, dp_last_reg;
  trk_t              trk_reg [LAT];
  trk_t              trk_tail;
  logic [CW-1:0]     inflight_reg, fifo_count;
  logic [CW:0]       used;
  logic              free_ok, accept, fifo_wr, fifo_rd, fifo_empty, sel_reg;
  logic [PAIR_W-1:0] fifo_rd_data;
  pair_t             wr_pair, head;

  // Credits cover both buffered pairs and pairs whose results are still owed
  assign used    = (CW+1)'(fifo_count) + (CW+1)'(inflight_reg);
  assign free_ok = used < (CW+1)'(FIFO_DEPTH);
  assign s_ready = free_ok;
  assign accept  = s_valid && free_ok;

  always_comb begin
    state_next = state_reg;
    held_next  = held_reg;
    timer_next = timer_reg;
    issue      = 1'b0;
    iss_x0     = '0;
    iss_x1     = '0;
    iss_mask   = 2'b00;
    iss_last   = 2'b00;
    unique case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          if (s_last) begin
            issue    = 1'b1;
            iss_x0   = s_data;
            iss_mask = 2'b01;
            iss_last = 2'b01;
          end else begin
            held_next  = s_data;
            timer_next = '0;
            state_next = ST_HALF;
          end
        end
      end
      ST_HALF: begin
        // A partner arriving in the timeout cycle beats the flush
        if (accept) begin
          issue      = 1'b1;
          iss_x0     = held_reg;
          iss_x1     = s_data;
          iss_mask   = 2'b11;
          iss_last   = {s_last, 1'b0};
          state_next = ST_IDLE;
        end else if (timer_reg == TIMEOUT) begin
          if (free_ok) begin
            issue      = 1'b1;
            iss_x0     = held_reg;
            iss_mask   = 2'b01;
            state_next = ST_IDLE;
          end
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      held_reg    <= '0;
      timer_reg   <= '0;
      dp_x0       <= '0;
      dp_x1       <= '0;
      dp_valid    <= 1'b0;
      dp_mask_reg <= 2'b00;
      dp_last_reg <= 2'b00;
    end else begin
      state_reg   <= state_next;
      held_reg    <= held_next;
      timer_reg   <= timer_next;
      dp_x0       <= iss_x0;
      dp_x1       <= iss_x1;
      dp_valid    <= issue;
      dp_mask_reg <= iss_mask;
      dp_last_reg <= iss_last;
    end
  end

  // Counted from the issuing edge so the pair is charged while dp_valid is high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_reg <= '0;
    end else begin
      case ({issue, dp_valid_out && (inflight_reg != '0)})
        2'b10:   inflight_reg <= inflight_reg + 1'b1;
        2'b01:   inflight_reg <= inflight_reg - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) trk_reg[i] <= '0;
      err <= 1'b0;
    end else begin
      trk_reg[0] <= {dp_valid, dp_mask_reg, dp_last_reg};
      for (int i = 1; i < LAT; i++) trk_reg[i] <= trk_reg[i-1];
      if (dp_valid_out != trk_tail.valid) err <= 1'b1;
    end
  end

  assign trk_tail     = trk_reg[LAT-1];
  assign fifo_wr      = dp_valid_out && trk_tail.valid;
  assign wr_pair.y0   = dp_y0;
  assign wr_pair.y1   = dp_y1;
  assign wr_pair.mask = trk_tail.mask;
  assign wr_pair.last = trk_tail.last;

  tanh_pair_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (fifo_wr),
    .wr_data (wr_pair),
    .rd_en   (fifo_rd),
    .rd_data (fifo_rd_data),
    .count   (fifo_count),
    .empty   (fifo_empty)
  );

  assign head    = pair_t'(fifo_rd_data);
  assign m_valid = !fifo_empty;
  assign m_data  = m_valid ? (sel_reg ? head.y1 : head.y0) : '0;
  assign m_last  = m_valid && (sel_reg ? head.last[1] : head.last[0]);
  // Pop after lane 1 of a full pair, or straight away for a lone lane 0
  assign fifo_rd = m_valid && m_ready && (sel_reg || (head.mask != 2'b11));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_reg <= 1'b0;
    end else if (m_valid && m_ready) begin
      sel_reg <= !sel_reg && (head.mask == 2'b11);
    end
  end

  assign busy = (state_reg == ST_HALF) || (inflight_reg != '0) || !fifo_empty;

endmodule

// File: tb/tb_tanh_pair_scheduler.sv
// Scoreboard bench for tanh_pair_scheduler with a behavioural LAT-cycle
// two-lane datapath stand-in whose response saturates at +/-2038 beyond |x|>=4.0.
module tb_tanh_pair_scheduler;
  import tanh_pkg::*;

  localparam int LAT        = 3;
  localparam int FIFO_DEPTH = 4;
  localparam int FLUSH_CYC  = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid, s_ready, s_last;
  logic [15:0] s_data;
  logic [15:0] dp_x0, dp_x1, dp_y0, dp_y1;
  logic        dp_valid, dp_valid_out;
  logic        m_valid, m_ready, m_last;
  logic [15:0] m_data;
  logic        busy, err;

  int checks   = 0;
  int errors   = 0;
  int accepted = 0;
  int dp_pulses = 0;
  logic [31:0] dp_log [$];
  logic [16:0] exp_q  [$];
  logic [16:0] sb_e;
  logic        drop_one = 1'b0;

  always #5 clk = ~clk;

  tanh_pair_scheduler #(
    .LAT(LAT), .FIFO_DEPTH(FIFO_DEPTH), .FLUSH_CYC(FLUSH_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .dp_x0(dp_x0), .dp_x1(dp_x1), .dp_valid(dp_valid),
    .dp_y0(dp_y0), .dp_y1(dp_y1), .dp_valid_out(dp_valid_out),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .err(err)
  );

  function automatic logic [15:0] tanh_ref(input logic [15:0] x);
    logic signed [15:0] sx;
    sx = x;
    if (sx >= 4 * Q_ONE) return 16'h07F6;
    if (sx <= -4 * Q_ONE) return 16'hF80A;
    return 16'(sx >>> 2);
  endfunction

  // Datapath stand-in, reset together with the scheduler
  logic [LAT-1:0] pv;
  logic [15:0]    p0 [LAT];
  logic [15:0]    p1 [LAT];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv <= '0;
    end else begin
      pv[0] <= dp_valid && !drop_one;
      p0[0] <= tanh_ref(dp_x0);
      p1[0] <= tanh_ref(dp_x1);
      for (int i = 1; i < LAT; i++) begin
        pv[i] <= pv[i-1];
        p0[i] <= p0[i-1];
        p1[i] <= p1[i-1];
      end
    end
  end
  assign dp_valid_out = pv[LAT-1];
  assign dp_y0 = p0[LAT-1];
  assign dp_y1 = p1[LAT-1];

  always @(negedge clk) begin
    if (dp_valid) begin
      dp_pulses++;
      dp_log.push_back({dp_x0, dp_x1});
      $display("issue x0=%h x1=%h", dp_x0, dp_x1);
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checks++;
      if (int'(dut.fifo_count) + int'(dut.inflight_reg) > FIFO_DEPTH) begin
        errors++;
        $display("FAIL credit_bound: got fifo+inflight=%0d, required <= %0d",
                 int'(dut.fifo_count) + int'(dut.inflight_reg), FIFO_DEPTH);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && m_valid === 1'b1 && m_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got data=%h last=%b, required none", m_data, m_last);
      end else begin
        sb_e = exp_q.pop_front();
        if ({m_last, m_data} !== sb_e) begin
          errors++;
          $display("FAIL scoreboard: got data=%h last=%b, required data=%h last=%b",
                   m_data, m_last, sb_e[15:0], sb_e[16]);
        end else begin
          $display("out   data=%h last=%b", m_data, m_last);
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic send(input logic [15:0] d, input logic l);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    while (s_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (s_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got s_ready=%b, required 1 within 200 cycles", s_ready);
      s_valid = 1'b0;
      return;
    end
    exp_q.push_back({l, tanh_ref(d)});
    accepted++;
    $display("in    data=%h last=%b", d, l);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL drain: got pending=%0d busy=%b, required 0 and 0", exp_q.size(), busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1;
    #2 rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({dp_x0, dp_x1, dp_valid, m_data, m_last, m_valid, err, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got x0=%h x1=%h dpv=%b md=%h ml=%b mv=%b err=%b busy=%b, required all 0",
               dp_x0, dp_x1, dp_valid, m_data, m_last, m_valid, err, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b1 || busy !== 1'b0 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got s_ready=%b busy=%b m_valid=%b, required 1 0 0", s_ready, busy, m_valid);
    end
  endtask

  task automatic test_lone_last();
    send(16'h0000, 1'b1);
    checks++;
    if (dp_valid !== 1'b1 || dp_x0 !== 16'h0000 || dp_x1 !== 16'h0000) begin
      errors++;
      $display("FAIL lone_issue: got dp_valid=%b x0=%h x1=%h, required 1 0000 0000", dp_valid, dp_x0, dp_x1);
    end
    // m_valid first appears in cycle k+LAT+2, i.e. after edge k+LAT+1
    for (int i = 1; i <= LAT + 1; i++) begin
      @(negedge clk);
      checks++;
      if (m_valid !== (i == LAT + 1)) begin
        errors++;
        $display("FAIL lone_latency: got m_valid=%b after edge k+%0d, required %b", m_valid, i, (i == LAT + 1));
      end
    end
    wait_drain();
  endtask

  task automatic test_back_to_back();
    int base;
    base = dp_pulses;
    send(16'hE000, 1'b0);
    send(16'h0000, 1'b0);
    send(16'h2000, 1'b0);
    send(16'h0000, 1'b1);
    wait_drain();
    checks++;
    if (dp_pulses - base != 2) begin
      errors++;
      $display("FAIL b2b_pulses: got %0d, required 2", dp_pulses - base);
    end else begin
      checks++;
      if (dp_log[base] !== 32'hE000_0000 || dp_log[base+1] !== 32'h2000_0000) begin
        errors++;
        $display("FAIL b2b_pairs: got %h %h, required e0000000 20000000", dp_log[base], dp_log[base+1]);
      end
    end
  endtask

  task automatic test_flush();
    int idx;
    idx = -1;
    send(16'h2000, 1'b0);
    for (int i = 0; i < 40; i++) begin
      if (dp_valid === 1'b1) begin
        idx = i;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (idx != FLUSH_CYC) begin
      errors++;
      $display("FAIL flush_delay: got dp_valid after %0d cycles, required %0d", idx, FLUSH_CYC);
    end
    checks++;
    if (dp_x0 !== 16'h2000 || dp_x1 !== 16'h0000) begin
      errors++;
      $display("FAIL flush_operands: got x0=%h x1=%h, required 2000 0000", dp_x0, dp_x1);
    end
    wait_drain();
  endtask

  task automatic test_timeout_partner();
    int base;
    base = dp_pulses;
    send(16'd100, 1'b0);
    repeat (FLUSH_CYC - 1) @(negedge clk);
    send(16'd200, 1'b1);
    checks++;
    if (dp_valid !== 1'b1 || dp_x0 !== 16'd100 || dp_x1 !== 16'd200) begin
      errors++;
      $display("FAIL partner_pair: got dp_valid=%b x0=%h x1=%h, required 1 0064 00c8", dp_valid, dp_x0, dp_x1);
    end
    repeat (FLUSH_CYC + 4) @(negedge clk);
    wait_drain();
    checks++;
    if (dp_pulses - base != 1) begin
      errors++;
      $display("FAIL partner_dup: got %0d issues, required 1", dp_pulses - base);
    end
  endtask

  task automatic test_backpressure();
    int base;
    base = accepted;
    @(posedge clk);
    #1 m_ready = 1'b0;
    @(negedge clk);
    fork
      begin
        for (int i = 0; i < 16; i++) send(16'(i * 300 - 2400), (i == 15));
      end
      begin
        repeat (30) @(negedge clk);
        checks++;
        if (accepted - base != 2 * FIFO_DEPTH || s_ready !== 1'b0) begin
          errors++;
          $display("FAIL stall_credit: got accepted=%0d s_ready=%b, required %0d and 0",
                   accepted - base, s_ready, 2 * FIFO_DEPTH);
        end
        @(posedge clk);
        #1 m_ready = 1'b1;
      end
    join
    wait_drain();
  endtask

  task automatic test_err();
    drop_one = 1'b1;
    send(16'd500, 1'b1);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_early: got err=%b, required 0", err);
    end
    @(posedge clk);
    #1 drop_one = 1'b0;
    for (int i = 1; i <= LAT + 1; i++) begin
      @(negedge clk);
      checks++;
      if (err !== (i == LAT + 1)) begin
        errors++;
        $display("FAIL err_timing: got err=%b after edge k+%0d, required %b", err, i, (i == LAT + 1));
      end
    end
    repeat (5) @(negedge clk);
    checks++;
    if (err !== 1'b1 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL err_sticky: got err=%b m_valid=%b, required 1 0", err, m_valid);
    end
    exp_q.delete();
    rst_n = 1'b0;
    #1;
    checks++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL err_reset: got err=%b busy=%b, required 0 0", err, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("FAIL err_recover: got s_ready=%b, required 1", s_ready);
    end
  endtask

  initial begin
    test_reset();
    test_lone_last();
    test_back_to_back();
    test_flush();
    test_timeout_partner();
    test_backpressure();
    test_err();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
